// File: rtl/cordic_arbiter.sv
// Two-requester round-robin front end for a fixed-latency CORDIC pipeline.
// A tag shift register routes each result back to its requester; per-requester credits bound in-flight work.
module cordic_arbiter #(
  parameter int unsigned N       = 16,
  parameter int unsigned LAT     = 16,
  parameter int unsigned MAX_OUT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_angle,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_angle,
  output logic         req1_ready,
  output logic [N-1:0] cordic_angle,
  input  logic [N-1:0] cordic_sine,
  input  logic [N-1:0] cordic_cosine,
  output logic         rsp0_valid,
  output logic [N-1:0] rsp0_sine,
  output logic [N-1:0] rsp0_cosine,
  output logic         rsp1_valid,
  output logic [N-1:0] rsp1_sine,
  output logic [N-1:0] rsp1_cosine,
  output logic         busy
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  logic [LAT-1:0] tag_v_q, tag_v_d;
  logic [LAT-1:0] tag_id_q, tag_id_d;
  logic           rr_q, rr_d;
  logic [CW-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic           rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [N-1:0]   rsp0_sine_q, rsp0_sine_d, rsp0_cosine_q, rsp0_cosine_d;
  logic [N-1:0]   rsp1_sine_q, rsp1_sine_d, rsp1_cosine_q, rsp1_cosine_d;

  logic elig0, elig1, issue0, issue1, issue;
  logic ret_v, ret_id;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_q       <= '0;
      tag_id_q      <= '0;
      rr_q          <= 1'b0;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_sine_q   <= '0;
      rsp0_cosine_q <= '0;
      rsp1_sine_q   <= '0;
      rsp1_cosine_q <= '0;
    end else begin
      tag_v_q       <= tag_v_d;
      tag_id_q      <= tag_id_d;
      rr_q          <= rr_d;
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_sine_q   <= rsp0_sine_d;
      rsp0_cosine_q <= rsp0_cosine_d;
      rsp1_sine_q   <= rsp1_sine_d;
      rsp1_cosine_q <= rsp1_cosine_d;
    end
  end

  // Arbitration and handshake outputs; nothing is granted while in reset
  always_comb begin
    elig0        = !rst && req0_valid && (cnt0_q < CW'(MAX_OUT));
    elig1        = !rst && req1_valid && (cnt1_q < CW'(MAX_OUT));
    issue0       = elig0 && (!elig1 || !rr_q);
    issue1       = elig1 && (!elig0 || rr_q);
    issue        = issue0 || issue1;
    req0_ready   = issue0;
    req1_ready   = issue1;
    cordic_angle = '0;
    if (issue0) begin
      cordic_angle = req0_angle;
    end else if (issue1) begin
      cordic_angle = req1_angle;
    end
  end

  // Next state: tag pipeline, pointer, credits, result capture
  always_comb begin
    ret_v         = tag_v_q[LAT-1];
    ret_id        = tag_id_q[LAT-1];
    tag_v_d       = (tag_v_q << 1) | LAT'(issue);
    tag_id_d      = (tag_id_q << 1) | LAT'(issue1);
    rr_d          = rr_q;
    cnt0_d        = cnt0_q;
    cnt1_d        = cnt1_q;
    rsp0_valid_d  = ret_v && !ret_id;
    rsp1_valid_d  = ret_v && ret_id;
    rsp0_sine_d   = rsp0_sine_q;
    rsp0_cosine_d = rsp0_cosine_q;
    rsp1_sine_d   = rsp1_sine_q;
    rsp1_cosine_d = rsp1_cosine_q;

    if (issue) begin
      rr_d = issue0;
    end

    if (issue0 && !rsp0_valid_q && cnt0_q != CW'(MAX_OUT)) begin
      cnt0_d = cnt0_q + CW'(1);
    end else if (!issue0 && rsp0_valid_q && cnt0_q != '0) begin
      cnt0_d = cnt0_q - CW'(1);
    end
    if (issue1 && !rsp1_valid_q && cnt1_q != CW'(MAX_OUT)) begin
      cnt1_d = cnt1_q + CW'(1);
    end else if (!issue1 && rsp1_valid_q && cnt1_q != '0) begin
      cnt1_d = cnt1_q - CW'(1);
    end

    if (rsp0_valid_d) begin
      rsp0_sine_d   = cordic_sine;
      rsp0_cosine_d = cordic_cosine;
    end
    if (rsp1_valid_d) begin
      rsp1_sine_d   = cordic_sine;
      rsp1_cosine_d = cordic_cosine;
    end
  end

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_sine   = rsp0_sine_q;
  assign rsp0_cosine = rsp0_cosine_q;
  assign rsp1_sine   = rsp1_sine_q;
  assign rsp1_cosine = rsp1_cosine_q;
  assign busy        = (|tag_v_q) || rsp0_valid_q || rsp1_valid_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Randomized bench for cordic_arbiter against a transaction-level model:
// credits, round-robin choice and a list of pending responses due at issue+LAT+1.
module tb_cordic_arbiter;

  localparam int unsigned N       = 16;
  localparam int unsigned LAT     = 16;
  localparam int unsigned MAX_OUT = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [N-1:0] req0_angle = '0, req1_angle = '0;
  logic         req0_ready, req1_ready;
  logic [N-1:0] cordic_angle, cordic_sine, cordic_cosine;
  logic         rsp0_valid, rsp1_valid;
  logic [N-1:0] rsp0_sine, rsp0_cosine, rsp1_sine, rsp1_cosine;
  logic         busy;

  cordic_arbiter #(.N(N), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_angle(req0_angle), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_angle(req1_angle), .req1_ready(req1_ready),
    .cordic_angle(cordic_angle), .cordic_sine(cordic_sine), .cordic_cosine(cordic_cosine),
    .rsp0_valid(rsp0_valid), .rsp0_sine(rsp0_sine), .rsp0_cosine(rsp0_cosine),
    .rsp1_valid(rsp1_valid), .rsp1_sine(rsp1_sine), .rsp1_cosine(rsp1_cosine),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in CORDIC: arbitrary per-angle functions, 0x2000 -> (0x1111, 0x2222)
  function automatic logic [N-1:0] f_sin(input logic [N-1:0] a);
    return (a == 16'h2000) ? 16'h1111 : N'(a * 3 + 1);
  endfunction
  function automatic logic [N-1:0] f_cos(input logic [N-1:0] a);
    return (a == 16'h2000) ? 16'h2222 : (~a ^ 16'h00ff);
  endfunction

  logic [N-1:0] ang_pipe [LAT];
  always @(posedge clk) begin
    ang_pipe[0] <= cordic_angle;
    for (int i = 1; i < LAT; i++) ang_pipe[i] <= ang_pipe[i-1];
  end
  assign cordic_sine   = f_sin(ang_pipe[LAT-1]);
  assign cordic_cosine = f_cos(ang_pipe[LAT-1]);

  typedef struct {
    int           due;
    bit           id;
    logic [N-1:0] ang;
  } pend_t;

  pend_t        pend[$];
  int           m_cnt [2];
  bit           m_rr;
  bit           e_rv  [2];
  logic [N-1:0] e_rs  [2];
  logic [N-1:0] e_rc  [2];
  int           cyc_n;
  int           n_vec, n_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc_n, got, exp);
    end
  endtask

  // One clock: drive inputs, compare against the model, then advance the model
  task automatic step(input bit r, input bit v0, input logic [N-1:0] a0,
                      input bit v1, input logic [N-1:0] a1, input bit chk);
    bit           el0, el1, g0, g1;
    logic [N-1:0] exp_ang;
    pend_t        p;
    @(posedge clk);
    #1;
    rst = r; req0_valid = v0; req0_angle = a0; req1_valid = v1; req1_angle = a1;
    #1;
    e_rv[0] = 0; e_rv[1] = 0;
    while (pend.size() != 0 && pend[0].due == cyc_n) begin
      p = pend.pop_front();
      e_rv[p.id] = 1; e_rs[p.id] = f_sin(p.ang); e_rc[p.id] = f_cos(p.ang);
    end
    el0 = !r && v0 && m_cnt[0] < MAX_OUT;
    el1 = !r && v1 && m_cnt[1] < MAX_OUT;
    if (el0 && el1) begin g0 = !m_rr; g1 = m_rr; end
    else begin g0 = el0; g1 = el1; end
    exp_ang = g0 ? a0 : (g1 ? a1 : '0);
    if (chk) begin
      check_val("req0_ready", 32'(req0_ready), 32'(g0));
      check_val("req1_ready", 32'(req1_ready), 32'(g1));
      check_val("cordic_angle", 32'(cordic_angle), 32'(exp_ang));
      check_val("rsp0_valid", 32'(rsp0_valid), 32'(e_rv[0]));
      check_val("rsp1_valid", 32'(rsp1_valid), 32'(e_rv[1]));
      check_val("rsp0_sine", 32'(rsp0_sine), 32'(e_rs[0]));
      check_val("rsp0_cosine", 32'(rsp0_cosine), 32'(e_rc[0]));
      check_val("rsp1_sine", 32'(rsp1_sine), 32'(e_rs[1]));
      check_val("rsp1_cosine", 32'(rsp1_cosine), 32'(e_rc[1]));
      check_val("busy", 32'(busy), 32'(pend.size() != 0 || e_rv[0] || e_rv[1]));
    end
    if (r) begin
      pend.delete();
      m_cnt[0] = 0; m_cnt[1] = 0; m_rr = 0;
      for (int k = 0; k < 2; k++) begin e_rs[k] = '0; e_rc[k] = '0; end
    end else begin
      if (g0 || g1) begin
        p.due = cyc_n + LAT + 1; p.id = g1; p.ang = exp_ang;
        pend.push_back(p);
        m_rr = g0;
      end
      m_cnt[0] = m_cnt[0] + int'(g0) - int'(e_rv[0]);
      m_cnt[1] = m_cnt[1] + int'(g1) - int'(e_rv[1]);
    end
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, 1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc_n = 0; m_rr = 0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    for (int k = 0; k < 2; k++) begin e_rv[k] = 0; e_rs[k] = '0; e_rc[k] = '0; end

    // Reset; registers are unknown until the first reset edge
    step(1, 0, '0, 0, '0, 0);
    step(1, 1, 16'h1234, 1, 16'h4321, 1);

    // Single request with the known angle
    step(0, 1, 16'h2000, 0, '0, 1);
    idle(LAT + 4);

    // Contention from reset
    step(1, 0, '0, 0, '0, 1);
    for (int i = 0; i < 60; i++)
      step(0, 1, N'($urandom), 1, N'($urandom), 1);
    idle(LAT + 4);

    // Credit limit on requester 0 alone
    step(1, 0, '0, 0, '0, 1);
    for (int i = 0; i < 50; i++) step(0, 1, N'($urandom), 0, '0, 1);
    idle(LAT + 4);

    // Lone requester 0 while the pointer favours requester 1
    step(1, 0, '0, 0, '0, 1);
    step(0, 1, 16'h0100, 0, '0, 1);
    step(0, 0, '0, 0, '0, 1);
    step(0, 1, 16'h0200, 0, '0, 1);
    step(0, 0, '0, 1, 16'h0300, 1);
    idle(LAT + 4);

    // Reset with five requests in flight
    for (int i = 0; i < 5; i++) step(0, 1, N'($urandom), 0, '0, 1);
    idle(2);
    step(1, 0, '0, 0, '0, 1);
    idle(LAT + 3);

    // Random traffic with rare resets
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, N'($urandom),
           $urandom_range(0, 2) != 0, N'($urandom), 1);
    idle(LAT + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
